// File: rtl/ctr_pkg.sv
// Shared definitions for the CTR-mode Feistel datapath: block geometry and packer states.
// Imported by the pixel packer, the encryptor and their benches.
package ctr_pkg;

    localparam int unsigned DATA_WIDTH  = 256;
    localparam int unsigned PIXEL_WIDTH = 8;
    localparam int unsigned BYTES       = DATA_WIDTH / PIXEL_WIDTH;

    // Width of a byte count that must represent 1..bytes inclusive.
    function automatic int unsigned nbytes_width(input int unsigned bytes);
        return $clog2(bytes) + 1;
    endfunction

    typedef enum logic {
        WAIT_KEY,
        FILL
    } state_e;

endpackage

// File: rtl/ctr_pixel_block_packer.sv
// Packs a byte-wide pixel stream into DATA_WIDTH plaintext blocks for the CTR encryptor.
// Input is held off until the key schedule first reports valid keys.
module ctr_pixel_block_packer #(
    parameter int unsigned              DATA_WIDTH  = ctr_pkg::DATA_WIDTH,
    parameter int unsigned              PIXEL_WIDTH = ctr_pkg::PIXEL_WIDTH,
    parameter logic [PIXEL_WIDTH-1:0]   PAD_BYTE    = '0,
    localparam int unsigned             BYTES       = DATA_WIDTH / PIXEL_WIDTH,
    localparam int unsigned             NB_W        = ctr_pkg::nbytes_width(BYTES)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   key_valid,
    input  logic                   s_tvalid,
    output logic                   s_tready,
    input  logic [PIXEL_WIDTH-1:0] s_tdata,
    input  logic                   s_tlast,
    output logic                   blk_tvalid,
    output logic [DATA_WIDTH-1:0]  blk_data,
    output logic                   blk_last,
    output logic [NB_W-1:0]        blk_nbytes,
    output logic [31:0]            blk_count
);
    import ctr_pkg::*;

    localparam int unsigned IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int unsigned LHI_W = $clog2(DATA_WIDTH);

    state_e                r_state;
    logic [IDX_W-1:0]      r_idx;
    logic [DATA_WIDTH-1:0] r_asm;

    logic [DATA_WIDTH-1:0] w_merged;
    logic [LHI_W-1:0]      w_lane_hi;
    logic                  w_acc;
    logic                  w_close;

    assign s_tready  = (r_state == FILL);
    assign w_acc     = s_tvalid && s_tready;
    assign w_close   = s_tlast || (r_idx == IDX_W'(BYTES - 1));
    // First pixel lands in the MSB lane.
    assign w_lane_hi = LHI_W'(DATA_WIDTH - 1 - 32'(r_idx) * PIXEL_WIDTH);

    always_comb begin
        w_merged = r_asm;
        w_merged[w_lane_hi -: PIXEL_WIDTH] = s_tdata;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= WAIT_KEY;
            r_idx      <= '0;
            r_asm      <= {BYTES{PAD_BYTE}};
            blk_tvalid <= 1'b0;
            blk_data   <= '0;
            blk_last   <= 1'b0;
            blk_nbytes <= '0;
            blk_count  <= '0;
        end else begin
            blk_tvalid <= 1'b0;
            unique case (r_state)
                WAIT_KEY: begin
                    if (key_valid) begin
                        r_state <= FILL;
                    end
                end
                FILL: begin
                    if (w_acc) begin
                        if (w_close) begin
                            // Unwritten lanes above idx still hold PAD_BYTE.
                            blk_data   <= w_merged;
                            blk_tvalid <= 1'b1;
                            blk_nbytes <= NB_W'(r_idx) + NB_W'(1);
                            blk_last   <= s_tlast;
                            blk_count  <= blk_count + 32'd1;
                            r_idx      <= '0;
                            r_asm      <= {BYTES{PAD_BYTE}};
                        end else begin
                            r_asm <= w_merged;
                            r_idx <= r_idx + IDX_W'(1);
                        end
                    end
                end
                default: r_state <= WAIT_KEY;
            endcase
        end
    end

endmodule

// File: doc/ctr_pixel_block_packer.md
Name: ctr_pixel_block_packer

Overview:
Upstream stage of the CTR-mode Feistel encryptor.
- Accepts the image as a byte-wide pixel stream with a valid/ready handshake.
- Packs 32 pixels into one 256-bit plaintext block and pulses the block into the encryptor's tvalid/plaintext inputs.
- The encryptor has no backpressure, so this block alone paces the stream. It holds off input until the key schedule reports valid keys.

Parameters:
- DATA_WIDTH, 256, block width in bits; must equal the encryptor's DATA_WIDTH.
- PIXEL_WIDTH, 8, pixel/byte width; DATA_WIDTH must be an integer multiple of it.
- PAD_BYTE, 8'h00, fill value for unfilled lanes of a final partial block.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- key_valid  in  1  from the key schedule; a one-cycle pulse or a level, both accepted
- s_tvalid  in  1  pixel valid
- s_tready  out  1  pixel ready
- s_tdata  in  PIXEL_WIDTH  pixel value
- s_tlast  in  1  last pixel of the image; qualified by s_tvalid
- blk_tvalid  out  1  one-cycle block strobe; drives the encryptor tvalid
- blk_data  out  DATA_WIDTH  packed plaintext block; drives the encryptor plaintext
- blk_last  out  1  block contains the image's final pixel
- blk_nbytes  out  $clog2(BYTES)+1  real (non-pad) bytes in blk_data, 1..BYTES
- blk_count  out  32  blocks emitted since reset

Behaviour:
- Constant BYTES = DATA_WIDTH/PIXEL_WIDTH, which is 32 at the defaults.
- Accept condition: acc = s_tvalid && s_tready.
- Reset values:
  - state = WAIT_KEY; lane index idx = 0; assembly register all PAD_BYTE.
  - blk_tvalid = 0, blk_data = 0, blk_last = 0, blk_nbytes = 0, blk_count = 0.
- State machine:
  - WAIT_KEY: s_tready = 0. Move to FILL on the edge where key_valid = 1.
  - FILL: s_tready = 1. Leave FILL only on reset; key_valid is ignored after the first time.
  - s_tready is decoded from the state register only, never from s_tvalid.
- Lane mapping: byte k of a block goes to bits [DATA_WIDTH-1-k*PIXEL_WIDTH -: PIXEL_WIDTH]. The first pixel is the MSB lane.
- On acc with idx < BYTES-1 and s_tlast = 0:
  - write s_tdata into lane idx;
  - idx <= idx+1;
  - no output strobe.
- On acc with idx == BYTES-1 or s_tlast = 1 (block close), at the same edge:
  - blk_data <= assembly with lane idx = s_tdata; lanes above idx keep PAD_BYTE;
  - blk_tvalid <= 1; blk_nbytes <= idx+1; blk_last <= s_tlast;
  - blk_count <= blk_count+1, wrapping modulo 2^32;
  - idx <= 0; assembly reset to all PAD_BYTE.
- Latency: blk_tvalid rises in the cycle after the edge that accepts the closing pixel.
- Output strobe and hold:
  - blk_tvalid is high for exactly one cycle per block and 0 in every other cycle.
  - blk_data, blk_last and blk_nbytes hold until the next close.
- Throughput: one pixel per cycle sustained.
  - With back-to-back single-pixel images (s_tlast every beat), blk_tvalid may be high on consecutive cycles. This is legal because the encryptor accepts a block every cycle.
- s_tlast on the 32nd byte: a single close event, with blk_nbytes = 32 and blk_last = 1. No extra empty block is emitted.
- Empty image: cannot occur, since s_tlast is meaningful only with s_tvalid. No block is emitted without an accepted pixel.
- s_tvalid = 0: state, idx and assembly are unchanged. Gaps inside a block are allowed.
- key_valid in the same cycle as s_tvalid while in WAIT_KEY: that pixel is not accepted. The first acceptance happens in the cycle after the transition.
- Reset mid-block: the partial block is discarded and no strobe is emitted. After reset the block waits for key_valid again.
- Stream protocol: s_tdata and s_tlast must stay stable while s_tvalid = 1 and s_tready = 0. This applies only in WAIT_KEY and is a bench assertion.

Decomposition:
- Shared package ctr_pkg holds:
  - DATA_WIDTH, PIXEL_WIDTH, the BYTES localparam and the blk_nbytes width function;
  - the state enum {WAIT_KEY, FILL}.
  The encryptor and its testbench import the same package.
- No sub-module: a lane-indexed write plus a small FSM is a single module. The top level instantiates this block next to the CTR encryptor and the key schedule.

Test Plan:
- Hold off: reset, s_tvalid = 1 with no key_valid for 20 cycles -> s_tready = 0, no blk_tvalid. Pulse key_valid -> s_tready = 1 on the next cycle.
- Full block: after key, stream bytes 8'h00..8'h1F back-to-back with s_tlast on 8'h1F -> one blk_tvalid the cycle after the 32nd accept:
  - blk_data = 256'h000102...1E1F, blk_nbytes = 32, blk_last = 1, blk_count = 1;
  - no second strobe follows.
- Partial tail: 40 bytes 8'hA0..8'hC7, s_tlast on byte 40 ->
  - block 1: 8'hA0..8'hBF, blk_nbytes = 32, blk_last = 0;
  - block 2: 8'hC0..8'hC7 in the top 8 lanes with 24 lanes of 8'h00, blk_nbytes = 8, blk_last = 1, blk_count = 2.
- Bubbles: 32 bytes with random s_tvalid gaps of 0–3 cycles -> blk_data identical to the gap-free run; strobe one cycle after the last accept.
- Single-pixel images: 4 consecutive beats each with s_tlast, data 8'h11, 8'h22, 8'h33, 8'h44 ->
  - four consecutive blk_tvalid cycles, each blk_nbytes = 1;
  - MSB lane = the pixel and the rest = PAD_BYTE.
- Reset mid-block: 10 bytes accepted, assert reset_n = 0 for 1 cycle ->
  - all outputs return to reset values and no strobe is emitted;
  - after key_valid, a new 32-byte block emits with blk_count = 1.
